// File: rtl/dmux_arb_pkg.sv
// Shared types and constants for the 8-way dmux arbiter.
// State encoding, requester count and select width.
package dmux_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/dmux_8_way.sv
// 1-to-8 demultiplexer: routes in to out[sel], all other bits 0.
// Purely combinational.
module dmux_8_way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic [7:0] out
);

    // Shift the single data bit into the selected lane.
    always_comb begin
        out = 8'(in) << sel;
    end

endmodule

// File: rtl/dmux_8_way_arbiter_rr_pick_8.sv
// Round-robin picker: first set bit of req & mask scanning from ptr.
// Combinational; mask lets the caller exclude the current owner.
import dmux_arb_pkg::*;

module rr_pick_8 (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] cand;
    logic [SEL_W-1:0]   pos;

    // Walk offsets high to low so the nearest offset from ptr wins last.
    always_comb begin
        cand  = req & mask;
        found = |cand;
        idx   = '0;
        pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = ptr + SEL_W'(k);
            if (cand[pos]) begin
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/dmux_8_way_arbiter.sv
// Round-robin arbiter steering one data bit through a dmux_8_way.
// Optional hold-time limit enabled by defining DMUX_ARB_TIMEOUT_EN.
import dmux_arb_pkg::*;

module dmux_8_way_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               in,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   select,
    output logic               valid,
    output logic [NUM_REQ-1:0] out
);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] mask;
    logic               found;
    logic [SEL_W-1:0]   idx;
    logic               owner_rel;
    logic               forced;
    logic               rearb;

`ifdef DMUX_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Owner has used its time slice and still asks for more.
    always_comb begin
        forced = (state_q == OWNED) && req[sel_q]
              && (cnt_q == 8'(HOLD_MAX - 1));
    end
`else
    logic [7:0] unused_hold;
    assign unused_hold = 8'(HOLD_MAX);
    assign forced      = 1'b0;
`endif

    // Exclude the current owner from any handover scan.
    always_comb begin
        mask = (state_q == OWNED) ? ~onehot(sel_q) : '1;
    end

    rr_pick_8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .mask  (mask),
        .found (found),
        .idx   (idx)
    );

    // Next-state: grant from idle, hand over on release, else hold.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        owner_rel = (state_q == OWNED) && !req[sel_q];
        rearb     = (state_q == IDLE) || owner_rel || forced;
        if (rearb) begin
            if (found) begin
                state_d = OWNED;
                grant_d = onehot(idx);
                sel_d   = idx;
                ptr_d   = idx + SEL_W'(1);
            end else if (!forced) begin
                state_d = IDLE;
                grant_d = '0;
                sel_d   = '0;
            end
        end
`ifdef DMUX_ARB_TIMEOUT_EN
        cnt_d = rearb ? 8'd0 : cnt_q + 8'd1;
`endif
    end

    // Register arbitration state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
`ifdef DMUX_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef DMUX_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign grant  = grant_q;
    assign select = sel_q;
    assign valid  = |grant_q;

    dmux_8_way u_dmux (
        .in  (in & valid),
        .sel (sel_q),
        .out (out)
    );

endmodule

// File: tb/tb_dmux_8_way_arbiter.sv
// Directed bench for dmux_8_way_arbiter with an integer-level model.
// Build with DMUX_ARB_TIMEOUT_EN defined to exercise the hold limit.
module tb_dmux_8_way_arbiter;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = '0;
    logic       in = 1'b0;
    logic [7:0] grant;
    logic [2:0] select;
    logic       valid;
    logic [7:0] out;

    int checks = 0;
    int errors = 0;

    dmux_8_way_arbiter #(.HOLD_MAX(HM)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .in     (in),
        .grant  (grant),
        .select (select),
        .valid  (valid),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 = idle), round-robin pointer, hold count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_live  = 0;
    bit m_rel;
    bit m_force;
    int m_win;

    always @(posedge clk) begin
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
            m_live  = 1;
        end else if (m_live) begin
            m_rel   = (m_owner >= 0) && !req[m_owner];
            m_force = 0;
`ifdef DMUX_ARB_TIMEOUT_EN
            m_force = (m_owner >= 0) && req[m_owner] && (m_cnt == HM - 1);
`endif
            if (m_owner < 0 || m_rel || m_force) begin
                m_win = -1;
                for (int k = 0; k < 8; k++) begin
                    int j;
                    j = (m_ptr + k) % 8;
                    if (m_win < 0 && req[j] && j != m_owner)
                        m_win = j;
                end
                m_cnt = 0;
                if (m_win >= 0) begin
                    m_owner = m_win;
                    m_ptr   = (m_win + 1) % 8;
                end else if (!m_force) begin
                    m_owner = -1;
                end
            end else begin
                m_cnt++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the edge.
    always @(posedge clk) begin
        #2;
        if (m_live) begin
            chk("m_grant", grant,
                (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("m_valid", valid, (m_owner >= 0) ? 1 : 0);
            chk("m_out", out,
                (m_owner >= 0 && in) ? (32'd1 << m_owner) : 32'd0);
            if (m_owner >= 0)
                chk("m_select", select, m_owner);
        end
    end

    task automatic step(input logic [7:0] r, input logic i,
                        input logic rst);
        @(negedge clk);
        req   = r;
        in    = i;
        reset = rst;
        @(posedge clk);
        #3;
    endtask

    logic [7:0] r;

    initial begin
        // Reset and idle
        step(8'h00, 1'b0, 1'b1);
        chk("rst_grant", grant, 0);
        chk("rst_select", select, 0);
        chk("rst_valid", valid, 0);
        chk("rst_out", out, 0);
        for (int n = 0; n < 5; n++) begin
            step(8'h00, 1'b1, 1'b0);
            chk("idle_grant", grant, 0);
            chk("idle_out", out, 0);
        end

        // Two requesters, release chain, pointer wrap
        step(8'h81, 1'b1, 1'b0);
        chk("g0_grant", grant, 8'h01);
        chk("g0_select", select, 0);
        chk("g0_out", out, 8'h01);
        step(8'h80, 1'b1, 1'b0);
        chk("g7_grant", grant, 8'h80);
        chk("g7_select", select, 7);
        chk("g7_out", out, 8'h80);
        step(8'h00, 1'b0, 1'b0);
        chk("g7_idle", valid, 0);
        step(8'h81, 1'b0, 1'b0);
        chk("wrap_grant", grant, 8'h01);
        step(8'h00, 1'b0, 1'b0);

        // All eight, each dropping right after its grant
        step(8'h00, 1'b0, 1'b1);
        r = 8'hFF;
        step(r, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant", grant, 32'd1 << k);
            chk("rr_valid", valid, 1);
            r[k] = 1'b0;
            step(r, 1'b0, 1'b0);
        end
        chk("rr_idle", grant, 0);

        // Owner 3 routing toggling data
        step(8'h00, 1'b0, 1'b1);
        step(8'h08, 1'b1, 1'b0);
        chk("o3_out1", out, 8'h08);
        step(8'h08, 1'b0, 1'b0);
        chk("o3_out0", out, 8'h00);
        step(8'h08, 1'b1, 1'b0);
        chk("o3_out1b", out, 8'h08);
        step(8'h00, 1'b0, 1'b0);

        // Reset mid-ownership, then regrant, then ignore others
        step(8'h20, 1'b1, 1'b0);
        chk("o5_grant", grant, 8'h20);
        step(8'h20, 1'b1, 1'b1);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_select", select, 0);
        chk("mid_rst_out", out, 0);
        step(8'h20, 1'b1, 1'b0);
        chk("o5_regrant", grant, 8'h20);
        chk("o5_select", select, 5);
        step(8'h2F, 1'b0, 1'b0);
        chk("o5_ignore", grant, 8'h20);
        step(8'h0F, 1'b0, 1'b0);
        chk("ptr6_handover", grant, 8'h01);
        step(8'h00, 1'b0, 1'b0);

        // Two steady requesters, with and without hold limit
        step(8'h00, 1'b0, 1'b1);
        for (int s = 0; s < 16; s++) begin
            step(8'h03, 1'b0, 1'b0);
`ifdef DMUX_ARB_TIMEOUT_EN
            chk("to_share", grant, ((s / HM) % 2) ? 8'h02 : 8'h01);
`else
            chk("hold_forever", grant, 8'h01);
`endif
        end
        step(8'h00, 1'b0, 1'b1);
        for (int s = 0; s < 10; s++) begin
            step(8'h01, 1'b0, 1'b0);
            chk("solo_hold", grant, 8'h01);
        end

        step(8'h00, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dmux_8_way_arbiter.md
# dmux_8_way_arbiter

Round-robin arbiter that shares one routed data bit among eight requesters by driving the select of an internal `dmux_8_way`. A requester raises its `req` bit, receives a registered one-hot grant, and owns the routing path until it drops `req`. It sits in front of any 8-destination fan-out, such as RAM8 load distribution, where exactly one destination may be driven at a time.

## Interface
- `HOLD_MAX`, default 16: maximum consecutive grant cycles per owner. Used only when `DMUX_ARB_TIMEOUT_EN` is defined. Legal range 1..255.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  8  request vector; bit i belongs to requester i.
- `in`  input  1  data bit to be routed to the current owner.
- `grant`  output  8  one-hot registered grant; all zero when idle.
- `select`  output  3  binary index of the owner; drives the internal dmux select.
- `valid`  output  1  high when a grant is held (equals `|grant`).
- `out`  output  8  `in` routed to `out[select]` when `valid`; all other bits 0. All bits 0 when not `valid`.

## Operation
- Two states: IDLE and OWNED.
- IDLE, `req` == 0: stay in IDLE.
- IDLE, `req` != 0: pick winner w, go to OWNED, set `grant` = 1<<w, `select` = w, `ptr` = (w+1) mod 8.
- Winner rule: the first set `req` bit scanning ptr, ptr+1, …, ptr+7 mod 8.
- OWNED, `req[select]` high: hold the grant unchanged.
- OWNED, `req[select]` low (release):
  - If another request is pending, hand over on the same edge to the next winner, scanning from `ptr`.
  - If none is pending, go to IDLE and clear `grant`.
- Handover never re-grants the releasing requester on the same edge. Its bit is low by definition.
- Changes in `req` from non-owners during OWNED are ignored until release.
- `out` is combinational from `in`, `select` and `valid`. It is produced by a `dmux_8_way` instance whose input is `in & valid`.

## Timing
- Reset (synchronous):
  - `grant` = 0, `select` = 0, `valid` = 0, `out` = 0.
  - `ptr` = 0, state = IDLE.
  - Hold counter = 0.
- Reset asserted mid-ownership drops the grant at that edge. `ptr` returns to 0.
- Grant latency: `req` sampled at edge N gives `grant` visible after edge N, i.e. one cycle.
- Release latency: `req[select]` low at edge N gives a new `grant` or idle after edge N. There is no dead cycle on handover.
- Simultaneous release and new requests: the new requests compete in the same arbitration.
- `ptr` wrap-around: after a grant to 7, `ptr` = 0.

## Configuration
- `DMUX_ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter runs during OWNED. It clears on every new grant, handover or IDLE entry.
  - When the counter reaches `HOLD_MAX`-1 and the owner still requests, the next edge is treated as a forced release. Handover uses the normal rule, excluding the current owner from the scan.
  - If no other request is pending, the owner keeps the grant and the counter restarts.
- `DMUX_ARB_TIMEOUT_EN` undefined:
  - No counter logic.
  - An owner holds the grant indefinitely while `req` stays high.
  - `HOLD_MAX` is unused.

## Structure
- Shared package `dmux_arb_pkg`:
  - state encoding (IDLE=0, OWNED=1)
  - `NUM_REQ`=8
  - `SEL_W`=3
- One sub-module: `rr_pick_8`.
  - Combinational.
  - Inputs: `req[7:0]`, `ptr[2:0]`, `mask[7:0]`.
  - Outputs: `found`, `idx[2:0]`.
  - `mask` removes the current owner during handover and forced release.
- Top level instantiates `rr_pick_8` and `dmux_8_way`.

## Test plan
- Reset then `req`=8'b0000_0000 for 5 cycles -> `grant`=0, `valid`=0, `out`=0 throughout.
- `req`=8'b1000_0001 from idle with `ptr`=0 -> `grant`=8'b0000_0001, `select`=0. Drop `req[0]` -> next cycle `grant`=8'b1000_0000, `select`=7. Drop `req[7]` -> IDLE, then `ptr`=0 (wrap).
- All eight requesters raise `req` and each drops one cycle after being granted -> grant order 0,1,2,…,7 with no idle cycle between grants.
- Owner 3 holding, `in` toggling 1,0,1 -> `out`=8'b0000_1000, 0, 8'b0000_1000. Other `out` bits stay 0.
- Reset asserted while owner 5 holds -> next cycle `grant`=0, `select`=0. With `req`=8'b0010_0000 after reset -> `grant`=8'b0010_0000.
- With `DMUX_ARB_TIMEOUT_EN`, `HOLD_MAX`=4, `req`=8'b0000_0011 held -> owner 0 for 4 cycles, then owner 1 for 4, repeating. With only `req[0]` -> owner 0 continuously.
